operand_stage: RTL and testbench

Decode/operand-fetch pipeline stage that sits directly upstream of the register file's read ports.
- Accepts 16-bit instructions from fetch over a valid/ready handshake.
- Decodes register fields and drives the file's two combinational read addresses.
- Bypasses same-cycle writeback data and tracks in-flight writers with a scoreboard to stall RAW/WAW hazards.
- Registers the decoded instruction and its operands for the execute stage.

---
 rtl/cpu_pkg.sv | 72 +++++++
 rtl/operand_stage_if.sv | 42 ++++
 rtl/operand_stage_scoreboard.sv | 31 +++
 rtl/operand_stage.sv | 109 ++++++++++
 tb/tb_operand_stage.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared decode definitions for the operand stage and execute: opcodes, field
// positions, the decoded instruction record and the decode function.
package cpu_pkg;

  localparam int INSTR_W   = 16;
  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 12;
  localparam int F11_LSB   = 9;
  localparam int F8_LSB    = 6;
  localparam int F5_LSB    = 3;
  localparam int FUNCT_LSB = 0;
  localparam int FUNCT_W   = 3;
  localparam int REG_W     = 3;
  localparam int IMM_W     = 6;

  typedef enum logic [3:0] {
    OP_RTYPE = 4'd0,
    OP_ADDI  = 4'd1,
    OP_ANDI  = 4'd2,
    OP_ORI   = 4'd3,
    OP_LW    = 4'd4,
    OP_SW    = 4'd5,
    OP_BEQ   = 4'd6,
    OP_J     = 4'd7
  } opcode_t;

  typedef struct packed {
    logic [3:0]              op;
    logic [FUNCT_W-1:0]      funct;
    logic                    we;
    logic [REG_W-1:0]        dest;
    logic [REG_W-1:0]        src1;
    logic [REG_W-1:0]        src2;
    logic                    use1;
    logic                    use2;
    logic signed [IMM_W-1:0] imm;
    logic                    illegal;
  } decoded_t;

  function automatic decoded_t decode(input logic [INSTR_W-1:0] instr);
    decoded_t         d;
    logic [REG_W-1:0] f11;
    logic [REG_W-1:0] f8;
    logic [REG_W-1:0] f5;
    f11     = instr[F11_LSB +: REG_W];
    f8      = instr[F8_LSB +: REG_W];
    f5      = instr[F5_LSB +: REG_W];
    d       = '0;
    d.op    = instr[OP_MSB:OP_LSB];
    d.funct = instr[FUNCT_LSB +: FUNCT_W];
    d.imm   = instr[IMM_W-1:0];
    case (instr[OP_MSB:OP_LSB])
      OP_RTYPE: begin
        d.src1 = f8;  d.use1 = 1'b1;
        d.src2 = f5;  d.use2 = 1'b1;
        d.dest = f11; d.we   = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_LW: begin
        d.src1 = f8;  d.use1 = 1'b1;
        d.dest = f11; d.we   = 1'b1;
      end
      OP_SW, OP_BEQ: begin
        d.src1 = f8;  d.use1 = 1'b1;
        d.src2 = f11; d.use2 = 1'b1;
      end
      OP_J: ;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/operand_stage_if.sv
// Bus bundle around the operand stage: fetch handshake, register-file read
// ports, writeback, flush and the execute payload.
interface operand_stage_if
  import cpu_pkg::*;
#(
  parameter int n = 16,
  parameter int r = 3
);
  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic               in_ready;
  logic [r-1:0]       ra1;
  logic [r-1:0]       ra2;
  logic [n-1:0]       rd1;
  logic [n-1:0]       rd2;
  logic               wb_we;
  logic [r-1:0]       wb_addr;
  logic [n-1:0]       wb_data;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         out_op;
  logic [FUNCT_W-1:0] out_funct;
  logic               out_we;
  logic [r-1:0]       out_dest;
  logic [n-1:0]       out_a;
  logic [n-1:0]       out_b;
  logic [n-1:0]       out_imm;
  logic               out_illegal;

  modport master (
    output in_valid, in_instr, rd1, rd2, wb_we, wb_addr, wb_data, flush, out_ready,
    input  in_ready, ra1, ra2, out_valid, out_op, out_funct, out_we, out_dest,
           out_a, out_b, out_imm, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, rd1, rd2, wb_we, wb_addr, wb_data, flush, out_ready,
    output in_ready, ra1, ra2, out_valid, out_op, out_funct, out_we, out_dest,
           out_a, out_b, out_imm, out_illegal
  );
endinterface

// File: rtl/operand_stage_scoreboard.sv
// In-flight writer tracking: one pending bit per register, set on issue,
// cleared on writeback or when the held writer is flushed.
module operand_stage_scoreboard #(
  parameter int r = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              set_en,
  input  logic [r-1:0]      set_addr,
  input  logic              clr_en,
  input  logic [r-1:0]      clr_addr,
  input  logic              flush_en,
  input  logic [r-1:0]      flush_addr,
  output logic [(1<<r)-1:0] pending
);
  logic [(1<<r)-1:0] pending_nxt;

  // Set is applied last so a new writer wins over a retiring one to the same register.
  always_comb begin
    pending_nxt = pending;
    if (clr_en)   pending_nxt[clr_addr]   = 1'b0;
    if (flush_en) pending_nxt[flush_addr] = 1'b0;
    if (set_en)   pending_nxt[set_addr]   = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) pending <= '0;
    else          pending <= pending_nxt;
  end
endmodule

// File: rtl/operand_stage.sv
// Decode/operand-fetch stage: decodes fetch instructions, reads and bypasses
// operands, stalls on scoreboard hazards and registers the payload for execute.
module operand_stage
  import cpu_pkg::*;
#(
  parameter int n = 16,
  parameter int r = 3
) (
  input logic            clock,
  input logic            reset_n,
  operand_stage_if.slave bus
);
  decoded_t              dec_p0;
  logic [r-1:0]          src1_p0;
  logic [r-1:0]          src2_p0;
  logic [r-1:0]          dest_p0;
  logic signed [n-1:0]   imm_p0;
  logic [(1<<r)-1:0]     pending;
  logic                  hazard;
  logic                  accept;

  logic                  vld_p1;
  logic [3:0]            op_p1;
  logic [FUNCT_W-1:0]    funct_p1;
  logic                  we_p1;
  logic [r-1:0]          dest_p1;
  logic signed [n-1:0]   a_p1;
  logic signed [n-1:0]   b_p1;
  logic signed [n-1:0]   imm_p1;
  logic                  illegal_p1;

  // Pending writer only blocks if it is not retiring on this very cycle.
  function automatic logic blocked(input logic [r-1:0] addr);
    return pending[addr] & ~(bus.wb_we & (bus.wb_addr == addr));
  endfunction

  function automatic logic [n-1:0] sel_operand(input logic [r-1:0] addr,
                                               input logic [n-1:0] rd);
    if (addr == '0)                           return '0;
    else if (bus.wb_we && bus.wb_addr == addr) return bus.wb_data;
    else                                      return rd;
  endfunction

  // ---- stage p0: decode, read addresses, hazard, accept ----
  assign dec_p0  = decode(bus.in_instr);
  assign src1_p0 = dec_p0.use1 ? r'(dec_p0.src1) : '0;
  assign src2_p0 = dec_p0.use2 ? r'(dec_p0.src2) : '0;
  assign dest_p0 = dec_p0.we   ? r'(dec_p0.dest) : '0;
  assign imm_p0  = {{(n-IMM_W){dec_p0.imm[IMM_W-1]}}, dec_p0.imm};

  assign bus.ra1 = src1_p0;
  assign bus.ra2 = src2_p0;

  // Unused fields decode to register 0, whose pending bit is never set.
  assign hazard       = blocked(src1_p0) | blocked(src2_p0) | blocked(dest_p0);
  assign bus.in_ready = reset_n & ~bus.flush & ~hazard & (~vld_p1 | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;

  operand_stage_scoreboard #(.r(r)) u_sb (
    .clock      (clock),
    .reset_n    (reset_n),
    .set_en     (accept & dec_p0.we & (dest_p0 != '0)),
    .set_addr   (dest_p0),
    .clr_en     (bus.wb_we),
    .clr_addr   (bus.wb_addr),
    .flush_en   (bus.flush & vld_p1 & we_p1),
    .flush_addr (dest_p1),
    .pending    (pending)
  );

  // ---- stage p1: execute payload ----
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vld_p1     <= 1'b0;
      op_p1      <= '0;
      funct_p1   <= '0;
      we_p1      <= 1'b0;
      dest_p1    <= '0;
      a_p1       <= '0;
      b_p1       <= '0;
      imm_p1     <= '0;
      illegal_p1 <= 1'b0;
    end else if (bus.flush) begin
      vld_p1     <= 1'b0;
    end else if (accept) begin
      vld_p1     <= 1'b1;
      op_p1      <= dec_p0.op;
      funct_p1   <= dec_p0.funct;
      we_p1      <= dec_p0.we;
      dest_p1    <= dest_p0;
      a_p1       <= sel_operand(src1_p0, bus.rd1);
      b_p1       <= sel_operand(src2_p0, bus.rd2);
      imm_p1     <= imm_p0;
      illegal_p1 <= dec_p0.illegal;
    end else if (bus.out_ready) begin
      vld_p1     <= 1'b0;
    end
  end

  assign bus.out_valid   = vld_p1;
  assign bus.out_op      = op_p1;
  assign bus.out_funct   = funct_p1;
  assign bus.out_we      = we_p1;
  assign bus.out_dest    = dest_p1;
  assign bus.out_a       = a_p1;
  assign bus.out_b       = b_p1;
  assign bus.out_imm     = imm_p1;
  assign bus.out_illegal = illegal_p1;
endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: directed scenarios with literal expectations, then
// random traffic checked each cycle against an instruction-level model.
module tb_operand_stage;
  localparam int N = 16;
  localparam int R = 3;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  operand_stage_if #(.n(N), .r(R)) bus ();
  operand_stage #(.n(N), .r(R)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  logic [N-1:0] regs [8];
  assign bus.rd1 = regs[bus.ra1];
  assign bus.rd2 = regs[bus.ra2];

  logic         m_valid, m_we, m_ill;
  logic [3:0]   m_op;
  logic [2:0]   m_funct, m_dest;
  logic [N-1:0] m_a, m_b, m_imm;
  logic [7:0]   m_pend;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit writes(input logic [3:0] op); return op <= 4'd4; endfunction
  function automatic bit reads1(input logic [3:0] op); return op <= 4'd6; endfunction
  function automatic bit reads2(input logic [3:0] op);
    return op == 4'd0 || op == 4'd5 || op == 4'd6;
  endfunction
  function automatic logic [2:0] src2_of(input logic [15:0] ins);
    return (ins[15:12] == 4'd0) ? ins[5:3] : ins[11:9];
  endfunction
  function automatic bit blocked(input logic [2:0] x);
    return x != 3'd0 && m_pend[x] && !(bus.wb_we && bus.wb_addr == x);
  endfunction
  function automatic logic [N-1:0] operand(input logic [2:0] x);
    if (x == 3'd0) return '0;
    if (bus.wb_we && bus.wb_addr == x) return bus.wb_data;
    return regs[x];
  endfunction

  task automatic drive(input logic v, input logic [15:0] ins, input logic ordy, input logic fl,
                       input logic we, input logic [2:0] wa, input logic [15:0] wd, input logic rn);
    bus.in_valid = v; bus.in_instr = ins; bus.out_ready = ordy; bus.flush = fl;
    bus.wb_we = we; bus.wb_addr = wa; bus.wb_data = wd; reset_n = rn;
  endtask

  // Called just after a falling edge with inputs driven; returns at the next falling edge.
  task automatic clk_step();
    logic [15:0] ins;
    logic [3:0]  op;
    logic [2:0]  s1, s2, d;
    bit          u1, u2, w, haz, rdy, acc;
    logic        nv, nwe, nill;
    logic [3:0]  nop;
    logic [2:0]  nfn, nd;
    logic [N-1:0] na, nb, nimm;
    logic [7:0]  np;
    ins = bus.in_instr; op = ins[15:12];
    s1 = ins[8:6]; s2 = src2_of(ins); d = ins[11:9];
    u1 = reads1(op); u2 = reads2(op); w = writes(op);
    haz = (u1 && blocked(s1)) || (u2 && blocked(s2)) || (w && blocked(d));
    rdy = reset_n && !bus.flush && !haz && (!m_valid || bus.out_ready);
    #1;
    chk("in_ready",  32'(bus.in_ready),  32'(rdy));
    chk("ra1",       32'(bus.ra1),       32'(u1 ? s1 : 3'd0));
    chk("ra2",       32'(bus.ra2),       32'(u2 ? s2 : 3'd0));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("out_op",    32'(bus.out_op),    32'(m_op));
    chk("out_we",    32'(bus.out_we),    32'(m_we));
    if (m_we)          chk("out_dest",  32'(bus.out_dest),  32'(m_dest));
    if (m_op == 4'd0)  chk("out_funct", 32'(bus.out_funct), 32'(m_funct));
    chk("out_a",       32'(bus.out_a),       32'(m_a));
    chk("out_b",       32'(bus.out_b),       32'(m_b));
    chk("out_imm",     32'(bus.out_imm),     32'(m_imm));
    chk("out_illegal", 32'(bus.out_illegal), 32'(m_ill));
    chk("pending",     32'(dut.pending),     32'(m_pend));

    acc = bus.in_valid && rdy;
    nv = m_valid; nop = m_op; nfn = m_funct; nwe = m_we; nd = m_dest;
    na = m_a; nb = m_b; nimm = m_imm; nill = m_ill; np = m_pend;
    if (!reset_n) begin
      nv = 0; nop = 0; nfn = 0; nwe = 0; nd = 0; na = 0; nb = 0; nimm = 0; nill = 0; np = 0;
    end else begin
      if (bus.wb_we) np[bus.wb_addr] = 1'b0;
      if (bus.flush && m_valid && m_we) np[m_dest] = 1'b0;
      if (acc && w && d != 3'd0) np[d] = 1'b1;
      np[0] = 1'b0;
      if (bus.flush) nv = 0;
      else if (acc) begin
        nv = 1; nop = op; nfn = ins[2:0]; nwe = w; nd = d;
        na = u1 ? operand(s1) : '0;
        nb = u2 ? operand(s2) : '0;
        nimm = {{(N-6){ins[5]}}, ins[5:0]};
        nill = op >= 4'd8;
      end else if (bus.out_ready) nv = 0;
    end
    @(posedge clock);
    #1;
    if (bus.wb_we) regs[bus.wb_addr] = bus.wb_data;
    m_valid = nv; m_op = nop; m_funct = nfn; m_we = nwe; m_dest = nd;
    m_a = na; m_b = nb; m_imm = nimm; m_ill = nill; m_pend = np;
    @(negedge clock);
  endtask

  initial begin
    logic [15:0] rnd;
    logic [2:0]  wa, st;
    for (int i = 0; i < 8; i++) regs[i] = 16'(i * 16'h0111);
    regs[0] = 16'hDEAD;
    regs[1] = 16'd5;
    regs[2] = 16'd7;
    drive(0, 16'h0, 1, 0, 0, 3'd0, 16'h0, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    m_valid = 0; m_op = 0; m_funct = 0; m_we = 0; m_dest = 0;
    m_a = 0; m_b = 0; m_imm = 0; m_ill = 0; m_pend = 0;

    // reset state
    clk_step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'h0);
    chk("rst_pending",   32'(dut.pending),   32'h0);

    // add r3,r1,r2
    drive(1, 16'h0650, 1, 0, 0, 3'd0, 16'h0, 1);
    #1 chk("add_ready", 32'(bus.in_ready), 32'h1);
    chk("add_ra1", 32'(bus.ra1), 32'h1);
    chk("add_ra2", 32'(bus.ra2), 32'h2);
    clk_step();
    chk("add_valid", 32'(bus.out_valid), 32'h1);
    chk("add_a",     32'(bus.out_a),     32'h5);
    chk("add_b",     32'(bus.out_b),     32'h7);
    chk("add_dest",  32'(bus.out_dest),  32'h3);
    chk("add_we",    32'(bus.out_we),    32'h1);
    chk("add_pend3", 32'(dut.pending[3]), 32'h1);

    // addi r1,r0,-1
    drive(1, 16'h123F, 1, 0, 0, 3'd0, 16'h0, 1);
    clk_step();
    chk("addi_imm", 32'(bus.out_imm), 32'hFFFF);
    chk("addi_a",   32'(bus.out_a),   32'h0);

    // writer to r2, then reader of r2 stalls until the writeback bypasses
    drive(1, 16'h1401, 1, 0, 0, 3'd0, 16'h0, 1);
    clk_step();
    drive(1, 16'h0A80, 1, 0, 0, 3'd0, 16'h0, 1);
    #1 chk("raw_stall", 32'(bus.in_ready), 32'h0);
    clk_step();
    drive(1, 16'h0A80, 1, 0, 1, 3'd2, 16'h1234, 1);
    #1 chk("raw_release", 32'(bus.in_ready), 32'h1);
    clk_step();
    chk("bypass_a",   32'(bus.out_a),       32'h1234);
    chk("bypass_p2",  32'(dut.pending[2]),  32'h0);

    // backpressure holds the payload
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'h7000, 0, 0, 0, 3'd0, 16'h0, 1);
      #1 chk("bp_ready", 32'(bus.in_ready), 32'h0);
      clk_step();
      chk("bp_a",    32'(bus.out_a),    32'h1234);
      chk("bp_dest", 32'(bus.out_dest), 32'h5);
    end
    drive(1, 16'h7000, 1, 0, 0, 3'd0, 16'h0, 1);
    #1 chk("bp_resume", 32'(bus.in_ready), 32'h1);
    clk_step();
    chk("j_op", 32'(bus.out_op), 32'h7);

    // held lw r4 then flush
    drive(1, 16'h4800, 1, 0, 0, 3'd0, 16'h0, 1);
    clk_step();
    chk("lw_pend4", 32'(dut.pending[4]), 32'h1);
    drive(0, 16'h0, 0, 1, 0, 3'd0, 16'h0, 1);
    #1 chk("flush_ready", 32'(bus.in_ready), 32'h0);
    clk_step();
    chk("flush_valid", 32'(bus.out_valid),    32'h0);
    chk("flush_pend4", 32'(dut.pending[4]),   32'h0);

    // writes to r0 never set a bit nor stall
    for (int i = 0; i < 2; i++) begin
      drive(1, 16'h01B0, 1, 0, 0, 3'd0, 16'h0, 1);
      #1 chk("r0_ready", 32'(bus.in_ready), 32'h1);
      clk_step();
      chk("r0_pend0", 32'(dut.pending[0]), 32'h0);
    end

    // reserved opcode
    drive(1, 16'hF123, 1, 0, 0, 3'd0, 16'h0, 1);
    #1 chk("ill_ra1", 32'(bus.ra1), 32'h0);
    chk("ill_ra2", 32'(bus.ra2), 32'h0);
    clk_step();
    chk("ill_flag", 32'(bus.out_illegal), 32'h1);
    chk("ill_we",   32'(bus.out_we),      32'h0);

    // reset while a payload is valid
    drive(0, 16'h0, 1, 0, 0, 3'd0, 16'h0, 0);
    clk_step();
    chk("rst2_valid", 32'(bus.out_valid), 32'h0);
    chk("rst2_pend",  32'(dut.pending),   32'h0);
    chk("rst2_a",     32'(bus.out_a),     32'h0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rnd = 16'($urandom());
      if ($urandom_range(0, 9) == 0) rnd[15:12] = 4'($urandom_range(8, 15));
      else                           rnd[15:12] = 4'($urandom_range(0, 7));
      wa = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        st = 3'($urandom_range(0, 7));
        for (int k = 0; k < 8; k++)
          if (m_pend[3'(int'(st) + k)]) begin wa = 3'(int'(st) + k); break; end
      end
      drive(1'($urandom_range(0, 9) < 7), rnd, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 4), wa,
            16'($urandom()), 1'($urandom_range(0, 199) != 0));
      clk_step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
